adam_aes_seq: RTL
=================

// Module: adam_aes_seq
// PURPOSE
//  Job sequencer for adam_aes_top's word register port. Accepts one 128-bit job (key, block, mode) on a
//  valid/ready port, drives the config/key/block writes, init/next strobes, status polling and result
//  reads, then returns the 128-bit result. Replaces software register banging for DMA/stream clients.
// PARAMETERS
//  POLL_TIMEOUT  1024  max STATUS polls per wait phase before aborting with res_err=1
//  DATA_WIDTH    32    core register width; fixed at 32
// PORTS
//  clk            in   1    clock (single clock domain)
//  reset_n        in   1    synchronous, active-low reset
//  job_valid      in   1    job request valid
//  job_ready      out  1    high only in IDLE
//  job_encdec     in   1    1=encrypt, 0=decrypt
//  job_rekey      in   1    1=force key load; ignored when no key loaded yet
//  job_key        in   128  key; word0=[127:96] written first
//  job_block      in   128  input block; same word order
//  res_valid      out  1    result valid, held until res_ready
//  res_ready      in   1    result accept
//  res_data       out  128  result; first read word lands in [127:96]
//  res_err        out  1    timeout abort; res_data=0 when set
//  busy           out  1    FSM not in IDLE
//  aes_cs         out  1    core select
//  aes_we         out  1    core write enable
//  aes_address    out  8    core word address
//  aes_write_data out  32   core write data
//  aes_read_data  in   32   core read data, valid same cycle as aes_cs=1, aes_we=0
// BEHAVIOUR
//  Core map: 0x00 CTRL (b0 init, b1 next, self-clearing); 0x04 STATUS (b0 ready, b1 valid);
//   0x08 CONFIG (b0 encdec); 0x0C KEY_PORT (4 writes shift key); 0x10 BLOCK_PORT (4 writes);
//   0x14 RESULT_PORT (each read pops next word, MSW first).
//  At most one core access per cycle; aes_cs=0, aes_we=0, address/data=0 in every non-access cycle.
//  States/transitions (each access state = 1 cycle per word):
//   IDLE: job_ready=1; job_valid -> latch key/block/encdec/rekey, go CFG.
//   CFG: write CONFIG={31'b0,encdec}; -> KEY if rekey, key_loaded=0, or encdec changed since last
//    key load; else -> BLK.
//   KEY: 4 writes to KEY_PORT (word0..3), 2-bit word counter; -> INIT.
//   INIT: write CTRL=0x1; clear poll counter; -> WAIT_K.
//   WAIT_K: read STATUS each cycle; b0=1 -> set key_loaded, latch key-mode encdec, -> BLK.
//   BLK: 4 writes to BLOCK_PORT; -> NEXT.   NEXT: write CTRL=0x2; clear poll counter; -> WAIT_B.
//   WAIT_B: read STATUS each cycle; b1=1 -> RD.
//   RD: 4 reads of RESULT_PORT, shift words into result reg; -> RESP.
//   RESP: res_valid=1, stable until res_ready; handshake -> IDLE (job_ready next cycle).
//  Poll counter: 11-bit saturating; in either WAIT state, reaching POLL_TIMEOUT polls without the
//   bit -> res_err=1, res_data=0, key_loaded=0, -> RESP. Non-timeout RESP has res_err=0.
//  Minimum latency accept->res_valid: no key load 1+4+1+1+4+1 = 12 cycles; with key load +6 (4 KEY,
//   INIT, 1 poll); each extra poll adds 1 cycle.
//  job_valid while busy: ignored (job_ready=0); job fields sampled only at acceptance.
//  RESP with res_ready low: all outputs frozen, no core accesses.
//  Reset (reset_n=0 at clk edge, any state incl. mid-job): state=IDLE, key_loaded=0,
//   job_ready=1 (IDLE), res_valid=0, res_err=0, res_data=0, busy=0, aes_cs=0, aes_we=0,
//   aes_address=0, aes_write_data=0; aborted job is dropped, no response.
// TESTING
//  T1 FIPS-197 key 000102..0f, pt 00112233445566778899aabbccddeeff, encrypt, rekey=1
//   -> res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_err=0, 4 KEY_PORT writes seen.
//  T2 second encrypt job same key, rekey=0 -> no CONFIG->KEY path, no KEY_PORT writes,
//   res_valid 12 cycles after accept (core ready immediately).
//  T3 decrypt of T1 ciphertext, rekey=0 -> key reload forced by mode change; result = T1 plaintext.
//  T4 core model never sets STATUS.b1, POLL_TIMEOUT=8 -> exactly 8 STATUS reads in WAIT_B, then
//   res_valid=1, res_err=1, res_data=0; next job reloads key.
//  T5 hold res_ready=0 for 20 cycles in RESP -> res_data stable, aes_cs=0 throughout, job_ready=0.
//  T6 assert reset_n=0 during KEY word 2 -> next cycle all outputs at reset values, job_ready=1;
//   following rekey=0 job still performs full key load.

Source files
------------

// File: rtl/adam_aes_seq_if.sv
// Job, result and core register-port signals shared by the AES job sequencer,
// its client and the adam_aes_top word port.
interface adam_aes_seq_if;
  logic         job_valid;
  logic         job_ready;
  logic         job_encdec;
  logic         job_rekey;
  logic [127:0] job_key;
  logic [127:0] job_block;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;
  logic         aes_cs;
  logic         aes_we;
  logic [7:0]   aes_address;
  logic [31:0]  aes_write_data;
  logic [31:0]  aes_read_data;

  // Sequencer side.
  modport slave (
    input  job_valid, job_encdec, job_rekey, job_key, job_block, res_ready, aes_read_data,
    output job_ready, res_valid, res_data, res_err, busy,
           aes_cs, aes_we, aes_address, aes_write_data
  );

  // Client plus core side.
  modport master (
    output job_valid, job_encdec, job_rekey, job_key, job_block, res_ready, aes_read_data,
    input  job_ready, res_valid, res_data, res_err, busy,
           aes_cs, aes_we, aes_address, aes_write_data
  );
endinterface

// File: rtl/adam_aes_seq.sv
// adam_aes_seq: takes one 128-bit AES job, drives the adam_aes_top word port
// (config, key, block, init/next, status polls, result reads) and returns the result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | job_ready=1, waiting for a job
// S_CFG    | write CONFIG with the job's encdec bit
// S_KEY    | four KEY_PORT writes, MSW first
// S_INIT   | write CTRL.init
// S_WAIT_K | poll STATUS until ready (b0) or poll limit
// S_BLK    | four BLOCK_PORT writes, MSW first
// S_NEXT   | write CTRL.next
// S_WAIT_B | poll STATUS until valid (b1) or poll limit
// S_RD     | four RESULT_PORT reads, first word ends up in [127:96]
// S_RESP   | res_valid=1, everything frozen until res_ready
module adam_aes_seq #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int DATA_WIDTH   = 32
) (
  input logic           clk,
  input logic           reset_n,
  adam_aes_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_KEY, S_INIT, S_WAIT_K, S_BLK, S_NEXT, S_WAIT_B, S_RD, S_RESP
  } state_t;

  localparam logic [7:0]  ADDR_CTRL   = 8'h00;
  localparam logic [7:0]  ADDR_STATUS = 8'h04;
  localparam logic [7:0]  ADDR_CONFIG = 8'h08;
  localparam logic [7:0]  ADDR_KEY    = 8'h0C;
  localparam logic [7:0]  ADDR_BLOCK  = 8'h10;
  localparam logic [7:0]  ADDR_RESULT = 8'h14;
  localparam logic [10:0] POLL_LIMIT  = 11'(POLL_TIMEOUT);

  state_t                  state_q, state_d;
  logic [127:0]            key_q, key_d;
  logic [127:0]            block_q, block_d;
  logic                    encdec_q, encdec_d;
  logic                    rekey_q, rekey_d;
  logic                    key_loaded_q, key_loaded_d;
  logic                    key_mode_q, key_mode_d;
  logic [1:0]              word_q, word_d;
  logic [10:0]             poll_q, poll_d, poll_inc;
  logic [127:0]            shift_q, shift_d;
  logic [127:0]            res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_err_q, res_err_d;
  logic                    job_ready_q, job_ready_d;
  logic                    busy_q, busy_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic [7:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    word_sel = v[127:96];
      2'd1:    word_sel = v[95:64];
      2'd2:    word_sel = v[63:32];
      default: word_sel = v[31:0];
    endcase
  endfunction

  // Next-state logic; the core port outputs are derived from the state being entered
  // so that every access is registered and lands in the cycle of its state.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    block_d      = block_q;
    encdec_d     = encdec_q;
    rekey_d      = rekey_q;
    key_loaded_d = key_loaded_q;
    key_mode_d   = key_mode_q;
    word_d       = '0;
    poll_d       = poll_q;
    poll_inc     = (poll_q == 11'h7FF) ? poll_q : poll_q + 11'd1;
    shift_d      = shift_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.job_valid) begin
          key_d    = bus.job_key;
          block_d  = bus.job_block;
          encdec_d = bus.job_encdec;
          rekey_d  = bus.job_rekey;
          state_d  = S_CFG;
        end
      end
      S_CFG: begin
        // The core's key schedule is mode dependent, so a mode change forces a reload.
        if (rekey_q || !key_loaded_q || (encdec_q != key_mode_q)) state_d = S_KEY;
        else                                                      state_d = S_BLK;
      end
      S_KEY: begin
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) state_d = S_INIT;
      end
      S_INIT: begin
        poll_d  = '0;
        state_d = S_WAIT_K;
      end
      S_WAIT_K: begin
        if (bus.aes_read_data[0]) begin
          key_loaded_d = 1'b1;
          key_mode_d   = encdec_q;
          state_d      = S_BLK;
        end else if (poll_inc >= POLL_LIMIT) begin
          key_loaded_d = 1'b0;
          res_err_d    = 1'b1;
          res_data_d   = '0;
          state_d      = S_RESP;
        end else begin
          poll_d = poll_inc;
        end
      end
      S_BLK: begin
        word_d = word_q + 2'd1;
        if (word_q == 2'd3) state_d = S_NEXT;
      end
      S_NEXT: begin
        poll_d  = '0;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (bus.aes_read_data[1]) begin
          state_d = S_RD;
        end else if (poll_inc >= POLL_LIMIT) begin
          key_loaded_d = 1'b0;
          res_err_d    = 1'b1;
          res_data_d   = '0;
          state_d      = S_RESP;
        end else begin
          poll_d = poll_inc;
        end
      end
      S_RD: begin
        word_d  = word_q + 2'd1;
        shift_d = {shift_q[95:0], bus.aes_read_data};
        if (word_q == 2'd3) begin
          res_data_d = {shift_q[95:0], bus.aes_read_data};
          res_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    res_valid_d = (state_d == S_RESP);
    job_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);

    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      S_CFG: begin
        cs_d = 1'b1; we_d = 1'b1; addr_d = ADDR_CONFIG;
        wdata_d = {{(DATA_WIDTH-1){1'b0}}, encdec_d};
      end
      S_KEY: begin
        cs_d = 1'b1; we_d = 1'b1; addr_d = ADDR_KEY;
        wdata_d = word_sel(key_d, word_d);
      end
      S_INIT: begin
        cs_d = 1'b1; we_d = 1'b1; addr_d = ADDR_CTRL;
        wdata_d = DATA_WIDTH'(1);
      end
      S_BLK: begin
        cs_d = 1'b1; we_d = 1'b1; addr_d = ADDR_BLOCK;
        wdata_d = word_sel(block_d, word_d);
      end
      S_NEXT: begin
        cs_d = 1'b1; we_d = 1'b1; addr_d = ADDR_CTRL;
        wdata_d = DATA_WIDTH'(2);
      end
      S_WAIT_K, S_WAIT_B: begin
        cs_d = 1'b1; addr_d = ADDR_STATUS;
      end
      S_RD: begin
        cs_d = 1'b1; addr_d = ADDR_RESULT;
      end
      default: ;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      block_q      <= '0;
      encdec_q     <= 1'b0;
      rekey_q      <= 1'b0;
      key_loaded_q <= 1'b0;
      key_mode_q   <= 1'b0;
      word_q       <= '0;
      poll_q       <= '0;
      shift_q      <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_err_q    <= 1'b0;
      job_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      block_q      <= block_d;
      encdec_q     <= encdec_d;
      rekey_q      <= rekey_d;
      key_loaded_q <= key_loaded_d;
      key_mode_q   <= key_mode_d;
      word_q       <= word_d;
      poll_q       <= poll_d;
      shift_q      <= shift_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_err_q    <= res_err_d;
      job_ready_q  <= job_ready_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.job_ready      = job_ready_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_err        = res_err_q;
  assign bus.busy           = busy_q;
  assign bus.aes_cs         = cs_q;
  assign bus.aes_we         = we_q;
  assign bus.aes_address    = addr_q;
  assign bus.aes_write_data = wdata_q;

endmodule
